vga_timing: RTL
===============

# vga_timing

Generates raster timing for the pong display: a pixel-enable strobe, `hcount`/`vcount` scan counters, active-low `hsync`/`vsync`, and blanking flags. It is the producer side of the scan interface consumed by the ball, paddle and score blocks, which compare `hcount`/`vcount` against object positions and update on vertical blank. It also provides a one-cycle `frame_tick` in the `clk` domain, so downstream movement logic can use a clock enable instead of clocking on `vblank` edges.

## Interface

Parameters:
- `CLK_DIV`, 2: `clk` cycles per pixel; 50 MHz board clock gives a 25 MHz pixel rate. Range 1..15.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- Constraint: `H_TOTAL` = sum of the H terms and `V_TOTAL` = sum of the V terms; each must be ≤ 2047.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `pix_en`  out  1  pixel strobe; high one `clk` cycle in every `CLK_DIV`.
- `hcount`  out  11  horizontal position, 0..`H_TOTAL`-1.
- `vcount`  out  11  vertical position, 0..`V_TOTAL`-1.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `hblank`  out  1  high when `hcount` ≥ `H_ACTIVE`.
- `vblank`  out  1  high when `vcount` ≥ `V_ACTIVE`.
- `blank`  out  1  `hblank` OR `vblank`.
- `frame_tick`  out  1  one-cycle pulse at the start of vertical blank.
- `frame_count`  out  8  frames completed, modulo 256.

## Operation

- Divider `d` (4 bits):
  - Resets to 0.
  - Each `clk` it increments, wrapping from `CLK_DIV`-1 to 0.
  - `pix_en` is high in cycles where `d`==`CLK_DIV`-1.
  - With `CLK_DIV`=1, `pix_en` is constantly 1 outside reset.
  - `pix_en` is forced to 0 while `rst_n`=0.
- Scan counters advance only on edges that end a `pix_en`=1 cycle:
  - `hcount` increments; at `H_TOTAL`-1 it wraps to 0 and `vcount` increments.
  - `vcount` wraps from `V_TOTAL`-1 to 0 on the same edge that `hcount` wraps.
- `hsync` is low iff `hcount` is in [`H_ACTIVE`+`H_FP`, `H_ACTIVE`+`H_FP`+`H_SYNC`-1]; with defaults, [656, 751].
- `vsync` is low iff `vcount` is in [`V_ACTIVE`+`V_FP`, `V_ACTIVE`+`V_FP`+`V_SYNC`-1]; with defaults, [490, 491].
- Sync and blank outputs are registers computed from the next counter values. They therefore change on the same edge as `hcount`/`vcount` and always decode the currently presented counts, with no skew.
- `frame_tick`:
  - High for exactly one `clk` cycle: the first cycle in which (`hcount`, `vcount`) = (0, `V_ACTIVE`).
  - It does not repeat during the remaining `CLK_DIV`-1 cycles of that pixel.
- `frame_count` increments on the same edge that sets `frame_tick`, and wraps from 255 to 0.

## Timing

- Reset values (registered on the first edge with `rst_n`=0):
  - `d`=0, `hcount`=0, `vcount`=0.
  - `hsync`=1, `vsync`=1.
  - `hblank`=0, `vblank`=0, `blank`=0.
  - `frame_tick`=0, `frame_count`=0, `pix_en`=0.
- After release with `CLK_DIV`=2:
  - First cycle after release: `pix_en`=0.
  - Second cycle: `pix_en`=1.
  - `hcount` becomes 1 in the third cycle.
- Each pixel position is held for exactly `CLK_DIV` cycles.
- Line period is `H_TOTAL`×`CLK_DIV` clocks; 1600 with defaults.
- Frame period is `H_TOTAL`×`V_TOTAL`×`CLK_DIV` clocks; 840000 with defaults.
- `frame_tick` period equals the frame period. It coincides with the rising edge of `vblank`.
- Reset asserted mid-frame: every output returns to its reset value on the next edge. The scan restarts at (0, 0) with no partial sync pulse held over.
- Double wrap at (`H_TOTAL`-1, `V_TOTAL`-1): both counters go to 0 on one edge. `vblank` falls and `vsync` stays high on that edge.
- No output depends combinationally on any input except `pix_en` on `rst_n`.

## Test plan

- Reset and cadence: hold `rst_n`=0 for 5 clks, then release with `CLK_DIV`=2.
  - During reset, all outputs show the reset values above.
  - After release, `pix_en` toggles 0,1,0,1.
  - `hcount` reads 0,0,1,1,2,2.
- Horizontal sync: run one line.
  - `hsync` falls when `hcount` goes 655→656 and rises when it goes 751→752, i.e. low for 192 clks.
  - `hblank` rises at `hcount`=640.
- Line and frame wrap:
  - (799, 10) → (0, 11).
  - (799, 524) → (0, 0), with `vblank` falling on that edge.
  - `vsync` is low for exactly `vcount` 490–491, i.e. 3200 clks.
- Frame tick: run 3 frames.
  - `frame_tick` is high for exactly 1 clk per frame, 840000 clks apart, each time at (0, 480).
  - `frame_count` reads 1, 2, 3.
- Counter wrap: preload by running 256 frames (`CLK_DIV`=1 for sim speed).
  - `frame_count` goes 255 → 0.
  - Frame period is 420000 clks.
- Mid-frame reset: assert `rst_n`=0 for 1 clk at (700, 491) while `vsync`=0.
  - Next cycle: `hcount`=0, `vcount`=0, `vsync`=1, `hsync`=1, `frame_count`=0.
  - The next `frame_tick` arrives 768000 clks after reset release.

Source files
------------

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Purpose  : Raster timing generator (pixel strobe, scan counters, syncs,
//            blanking, per-frame tick and frame counter).
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        pix_en,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic        blank,
    output logic        frame_tick,
    output logic [7:0]  frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  c_div_last = 4'(CLK_DIV - 1);
    localparam logic [10:0] c_h_last   = 11'(H_TOTAL - 1);
    localparam logic [10:0] c_v_last   = 11'(V_TOTAL - 1);
    localparam logic [10:0] c_h_active = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_active = 11'(V_ACTIVE);
    localparam logic [10:0] c_hs_start = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] c_vs_start = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_end   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [3:0]  r_div;
    logic        w_pix_last;
    logic [3:0]  w_div_next;
    logic        w_h_wrap;
    logic [10:0] w_h_next;
    logic [10:0] w_v_next;
    logic        w_hsync_next;
    logic        w_vsync_next;
    logic        w_hblank_next;
    logic        w_vblank_next;
    logic        w_tick_next;

    assign w_pix_last = (r_div == c_div_last);
    assign w_div_next = w_pix_last ? 4'd0 : r_div + 4'd1;

    // The strobe is the only output allowed to see reset combinationally.
    assign pix_en = rst_n & w_pix_last;

    always_comb begin
        w_h_wrap = (hcount == c_h_last);
        w_h_next = w_h_wrap ? 11'd0 : hcount + 11'd1;
        w_v_next = vcount;
        if (w_h_wrap) begin
            w_v_next = (vcount == c_v_last) ? 11'd0 : vcount + 11'd1;
        end
    end

    // Decode from the next counts so registered flags line up with the counters.
    always_comb begin
        w_hsync_next  = !((w_h_next >= c_hs_start) && (w_h_next <= c_hs_end));
        w_vsync_next  = !((w_v_next >= c_vs_start) && (w_v_next <= c_vs_end));
        w_hblank_next = (w_h_next >= c_h_active);
        w_vblank_next = (w_v_next >= c_v_active);
        w_tick_next   = (w_h_next == 11'd0) && (w_v_next == c_v_active);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div       <= 4'd0;
            hcount      <= 11'd0;
            vcount      <= 11'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            blank       <= 1'b0;
            frame_tick  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            r_div      <= w_div_next;
            frame_tick <= 1'b0;
            if (w_pix_last) begin
                hcount     <= w_h_next;
                vcount     <= w_v_next;
                hsync      <= w_hsync_next;
                vsync      <= w_vsync_next;
                hblank     <= w_hblank_next;
                vblank     <= w_vblank_next;
                blank      <= w_hblank_next | w_vblank_next;
                frame_tick <= w_tick_next;
                if (w_tick_next) begin
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
